// File: rtl/fic_apb_pkg.sv
// Shared types and helpers for the FIC_0 APB two-requester arbiter.
// Holds the transfer FSM encoding, requester indices and the watchdog width rule.
package fic_apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    localparam int REQ_M0 = 0;
    localparam int REQ_M1 = 1;

    // A disabled watchdog (0) still needs a 1-bit counter to keep the RTL legal.
    function automatic int wdog_cnt_width(input int timeout_cycles);
        return (timeout_cycles < 1) ? 1 : $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick: on a tie the requester not granted last wins.
// Latency: combinational. Backpressure: none, the caller decides when to sample.
// last_grant carries the index of the previous owner (0 = M0, 1 = M1).
module rr_arbiter_2
    import fic_apb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req[REQ_M0] && req[REQ_M1]) begin
            grant = '0;
            if (last_grant) begin
                grant[REQ_M0] = 1'b1;
            end else begin
                grant[REQ_M1] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fic_0_apb_arbiter.sv
// Shares the FIC_0 APB completer between the MSS master (M0) and a fabric master (M1).
// Latency: 3 cycles setup-to-PREADY with a zero-wait completer, +1 per downstream wait.
// Backpressure: the non-owner is held with PREADY=0; a watchdog aborts hung accesses.
module fic_0_apb_arbiter
    import fic_apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  MCCC_CLK_BASE,
    input  logic                  RESET,

    input  logic                  M0_PSEL,
    input  logic                  M0_PENABLE,
    input  logic                  M0_PWRITE,
    input  logic [ADDR_WIDTH-1:0] M0_PADDR,
    input  logic [DATA_WIDTH-1:0] M0_PWDATA,
    output logic [DATA_WIDTH-1:0] M0_PRDATA,
    output logic                  M0_PREADY,
    output logic                  M0_PSLVERR,

    input  logic                  M1_PSEL,
    input  logic                  M1_PENABLE,
    input  logic                  M1_PWRITE,
    input  logic [ADDR_WIDTH-1:0] M1_PADDR,
    input  logic [DATA_WIDTH-1:0] M1_PWDATA,
    output logic [DATA_WIDTH-1:0] M1_PRDATA,
    output logic                  M1_PREADY,
    output logic                  M1_PSLVERR,

    output logic                  S_PSEL,
    output logic                  S_PENABLE,
    output logic                  S_PWRITE,
    output logic [ADDR_WIDTH-1:0] S_PADDR,
    output logic [DATA_WIDTH-1:0] S_PWDATA,
    input  logic [DATA_WIDTH-1:0] S_PRDATA,
    input  logic                  S_PREADY,
    input  logic                  S_PSLVERR,

    output logic [1:0]            GRANT,
    output logic                  TIMEOUT_PULSE
);

    localparam int              CNT_W    = wdog_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit              WDOG_EN  = (TIMEOUT_CYCLES != 0);

    apb_state_e       state_q;
    apb_state_e       state_d;
    logic [CNT_W-1:0] wdog_cnt_q;
    logic             last_grant_q;

    logic [1:0]       req;
    logic [1:0]       arb_grant;
    logic             load_req;
    logic             wdog_abort;
    logic             access_done;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic             rsp_err;

    logic                  s_psel_d;
    logic                  s_penable_d;
    logic                  s_pwrite_d;
    logic [ADDR_WIDTH-1:0] s_paddr_d;
    logic [DATA_WIDTH-1:0] s_pwdata_d;
    logic [1:0]            grant_d;
    logic                  timeout_pulse_d;
    logic                  m0_pready_d;
    logic                  m0_pslverr_d;
    logic [DATA_WIDTH-1:0] m0_prdata_d;
    logic                  m1_pready_d;
    logic                  m1_pslverr_d;
    logic [DATA_WIDTH-1:0] m1_prdata_d;

    // A request is pending on PSEL alone; PENABLE carries no extra information here.
    logic unused_penable;
    assign unused_penable = M0_PENABLE ^ M1_PENABLE;

    assign req[REQ_M0] = M0_PSEL;
    assign req[REQ_M1] = M1_PSEL;

    rr_arbiter_2 u_rr_arbiter_2 (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (arb_grant)
    );

    assign wdog_abort  = WDOG_EN && (state_q == ST_ACCESS) && !S_PREADY
                         && (wdog_cnt_q == CNT_LAST);
    assign access_done = (state_q == ST_ACCESS) && (S_PREADY || wdog_abort);
    assign load_req    = (state_q == ST_IDLE) && (state_d == ST_SETUP);

    always_ff @(posedge MCCC_CLK_BASE or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (|req) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (access_done) state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Watchdog counts stalled ACCESS cycles of the current transfer only.
    always_ff @(posedge MCCC_CLK_BASE or posedge RESET) begin
        if (RESET) begin
            wdog_cnt_q   <= '0;
            last_grant_q <= 1'b1;
        end else begin
            if (load_req) begin
                wdog_cnt_q <= '0;
            end else if ((state_q == ST_ACCESS) && !S_PREADY) begin
                wdog_cnt_q <= wdog_cnt_q + 1'b1;
            end
            if (state_q == ST_RESP) begin
                last_grant_q <= GRANT[REQ_M1];
            end
        end
    end

    // Outputs are computed from the next state so every port comes straight off a flop.
    always_comb begin
        s_psel_d    = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        s_penable_d = (state_d == ST_ACCESS);
        s_pwrite_d  = S_PWRITE;
        s_paddr_d   = S_PADDR;
        s_pwdata_d  = S_PWDATA;
        grant_d     = GRANT;

        if (load_req) begin
            grant_d = arb_grant;
            if (arb_grant[REQ_M1]) begin
                s_pwrite_d = M1_PWRITE;
                s_paddr_d  = M1_PADDR;
                s_pwdata_d = M1_PWDATA;
            end else begin
                s_pwrite_d = M0_PWRITE;
                s_paddr_d  = M0_PADDR;
                s_pwdata_d = M0_PWDATA;
            end
        end else if (!s_psel_d) begin
            s_pwrite_d = 1'b0;
            s_paddr_d  = '0;
            s_pwdata_d = '0;
        end

        if (state_d == ST_IDLE) begin
            grant_d = '0;
        end

        rsp_rdata = wdog_abort ? '0 : S_PRDATA;
        rsp_err   = wdog_abort | S_PSLVERR;

        m0_pready_d  = access_done && GRANT[REQ_M0];
        m0_prdata_d  = m0_pready_d ? rsp_rdata : '0;
        m0_pslverr_d = m0_pready_d && rsp_err;
        m1_pready_d  = access_done && GRANT[REQ_M1];
        m1_prdata_d  = m1_pready_d ? rsp_rdata : '0;
        m1_pslverr_d = m1_pready_d && rsp_err;

        timeout_pulse_d = wdog_abort;
    end

    // Async reset drops the downstream transfer immediately and never answers the owner.
    always_ff @(posedge MCCC_CLK_BASE or posedge RESET) begin
        if (RESET) begin
            S_PSEL        <= 1'b0;
            S_PENABLE     <= 1'b0;
            S_PWRITE      <= 1'b0;
            S_PADDR       <= '0;
            S_PWDATA      <= '0;
            GRANT         <= '0;
            TIMEOUT_PULSE <= 1'b0;
            M0_PREADY     <= 1'b0;
            M0_PRDATA     <= '0;
            M0_PSLVERR    <= 1'b0;
            M1_PREADY     <= 1'b0;
            M1_PRDATA     <= '0;
            M1_PSLVERR    <= 1'b0;
        end else begin
            S_PSEL        <= s_psel_d;
            S_PENABLE     <= s_penable_d;
            S_PWRITE      <= s_pwrite_d;
            S_PADDR       <= s_paddr_d;
            S_PWDATA      <= s_pwdata_d;
            GRANT         <= grant_d;
            TIMEOUT_PULSE <= timeout_pulse_d;
            M0_PREADY     <= m0_pready_d;
            M0_PRDATA     <= m0_prdata_d;
            M0_PSLVERR    <= m0_pslverr_d;
            M1_PREADY     <= m1_pready_d;
            M1_PRDATA     <= m1_prdata_d;
            M1_PSLVERR    <= m1_pslverr_d;
        end
    end

endmodule

// File: tb/tb_fic_0_apb_arbiter.sv
// Bench for fic_0_apb_arbiter: directed APB transfers on both requesters against a
// timeline model of each transfer, plus hand-computed latency/data/order expectations.
module tb_fic_0_apb_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic          clk;
    logic          rst;
    logic          m0_psel, m0_penable, m0_pwrite;
    logic [AW-1:0] m0_paddr;
    logic [DW-1:0] m0_pwdata, m0_prdata;
    logic          m0_pready, m0_pslverr;
    logic          m1_psel, m1_penable, m1_pwrite;
    logic [AW-1:0] m1_paddr;
    logic [DW-1:0] m1_pwdata, m1_prdata;
    logic          m1_pready, m1_pslverr;
    logic          s_psel, s_penable, s_pwrite;
    logic [AW-1:0] s_paddr;
    logic [DW-1:0] s_pwdata, s_prdata;
    logic          s_pready, s_pslverr;
    logic [1:0]    grant;
    logic          timeout_pulse;

    fic_0_apb_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .MCCC_CLK_BASE (clk),
        .RESET         (rst),
        .M0_PSEL       (m0_psel),
        .M0_PENABLE    (m0_penable),
        .M0_PWRITE     (m0_pwrite),
        .M0_PADDR      (m0_paddr),
        .M0_PWDATA     (m0_pwdata),
        .M0_PRDATA     (m0_prdata),
        .M0_PREADY     (m0_pready),
        .M0_PSLVERR    (m0_pslverr),
        .M1_PSEL       (m1_psel),
        .M1_PENABLE    (m1_penable),
        .M1_PWRITE     (m1_pwrite),
        .M1_PADDR      (m1_paddr),
        .M1_PWDATA     (m1_pwdata),
        .M1_PRDATA     (m1_prdata),
        .M1_PREADY     (m1_pready),
        .M1_PSLVERR    (m1_pslverr),
        .S_PSEL        (s_psel),
        .S_PENABLE     (s_penable),
        .S_PWRITE      (s_pwrite),
        .S_PADDR       (s_paddr),
        .S_PWDATA      (s_pwdata),
        .S_PRDATA      (s_prdata),
        .S_PREADY      (s_pready),
        .S_PSLVERR     (s_pslverr),
        .GRANT         (grant),
        .TIMEOUT_PULSE (timeout_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream completer: ready after slv_wait stalled ACCESS cycles, or never.
    int          slv_wait;
    bit          slv_stuck;
    bit          slv_err;
    logic [DW-1:0] slv_rdata;
    int          acc_cnt;

    always @(posedge clk) acc_cnt <= (s_psel && s_penable) ? acc_cnt + 1 : 0;
    assign s_pready  = s_psel && s_penable && !slv_stuck && (acc_cnt == slv_wait);
    assign s_prdata  = slv_rdata;
    assign s_pslverr = slv_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Transfer timeline model: a granted transfer is SETUP the cycle after the grant
    // decision, ACCESS until the completer answers or TMO stalled cycles pass, then one
    // response cycle before the bus is free again.
    int            m_owner;
    int            m_last;
    int            m_t_grant;
    int            m_t_done;
    bit            m_abort;
    logic [DW-1:0] m_rdata;
    bit            m_err;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    bit            m_write;

    logic          e_s_psel, e_s_penable, e_s_pwrite, e_pulse;
    logic [AW-1:0] e_s_paddr;
    logic [DW-1:0] e_s_pwdata;
    logic [1:0]    e_grant;
    logic [1:0]    e_pready, e_pslverr;
    logic [DW-1:0] e_prdata [2];

    task automatic clear_expect();
        e_s_psel = 0; e_s_penable = 0; e_s_pwrite = 0; e_pulse = 0;
        e_s_paddr = '0; e_s_pwdata = '0; e_grant = 2'b00;
        e_pready = 2'b00; e_pslverr = 2'b00;
        e_prdata[0] = '0; e_prdata[1] = '0;
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 1;
        clear_expect();
    endtask

    task automatic model_step();
        int c;
        if (m_owner < 0) begin
            if (m0_psel || m1_psel) begin
                if (m0_psel && m1_psel) m_owner = (m_last == 1) ? 0 : 1;
                else                    m_owner = m0_psel ? 0 : 1;
                m_t_grant = cyc;
                m_t_done  = -1;
                m_abort   = 0;
                m_addr    = (m_owner == 0) ? m0_paddr  : m1_paddr;
                m_wdata   = (m_owner == 0) ? m0_pwdata : m1_pwdata;
                m_write   = (m_owner == 0) ? m0_pwrite : m1_pwrite;
            end
        end else if (m_t_done < 0) begin
            if (cyc >= m_t_grant + 2) begin
                if (s_pready) begin
                    m_t_done = cyc; m_rdata = s_prdata; m_err = s_pslverr;
                end else if (cyc - m_t_grant - 1 == TMO) begin
                    m_t_done = cyc; m_rdata = '0; m_err = 1; m_abort = 1;
                end
            end
        end else begin
            m_last  = m_owner;
            m_owner = -1;
        end

        c = cyc + 1;
        clear_expect();
        if (m_owner >= 0) begin
            e_grant = (m_owner == 0) ? 2'b01 : 2'b10;
            if (m_t_done < 0) begin
                e_s_psel    = 1;
                e_s_penable = (c >= m_t_grant + 2);
                e_s_paddr   = m_addr;
                e_s_pwdata  = m_wdata;
                e_s_pwrite  = m_write;
            end else begin
                e_pready[m_owner]  = 1;
                e_pslverr[m_owner] = m_err;
                e_prdata[m_owner]  = m_rdata;
                e_pulse            = m_abort;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) model_reset();
        chk("S_PSEL",        32'(s_psel),        32'(e_s_psel));
        chk("S_PENABLE",     32'(s_penable),     32'(e_s_penable));
        chk("S_PWRITE",      32'(s_pwrite),      32'(e_s_pwrite));
        chk("S_PADDR",       s_paddr,            e_s_paddr);
        chk("S_PWDATA",      s_pwdata,           e_s_pwdata);
        chk("GRANT",         32'(grant),         32'(e_grant));
        chk("TIMEOUT_PULSE", 32'(timeout_pulse), 32'(e_pulse));
        chk("M0_PREADY",     32'(m0_pready),     32'(e_pready[0]));
        chk("M0_PSLVERR",    32'(m0_pslverr),    32'(e_pslverr[0]));
        chk("M0_PRDATA",     m0_prdata,          e_prdata[0]);
        chk("M1_PREADY",     32'(m1_pready),     32'(e_pready[1]));
        chk("M1_PSLVERR",    32'(m1_pslverr),    32'(e_pslverr[1]));
        chk("M1_PRDATA",     m1_prdata,          e_prdata[1]);
        if (!rst) model_step();
        cyc++;
    end

    // Observers feeding the hand-computed expectations.
    int            acc_cycles = 0;
    int            pulse_cnt  = 0;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;
    logic [1:0]    prev_grant = 2'b00;
    logic [1:0]    grant_log [$];

    always @(negedge clk) begin
        if (s_psel && s_penable) begin
            acc_cycles++;
            acc_addr  = s_paddr;
            acc_wdata = s_pwdata;
        end
        if (timeout_pulse) pulse_cnt++;
        if (grant != 2'b00 && prev_grant == 2'b00) grant_log.push_back(grant);
        prev_grant = grant;
    end

    task automatic drive(input int p, input bit sel, input bit en, input bit wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            m0_psel = sel; m0_penable = en; m0_pwrite = wr; m0_paddr = a; m0_pwdata = d;
        end else begin
            m1_psel = sel; m1_penable = en; m1_pwrite = wr; m1_paddr = a; m1_pwdata = d;
        end
    endtask

    // Called just after a rising edge; lat counts cycles from T0 to the PREADY cycle.
    task automatic xfer(input int p, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output logic [DW-1:0] rd,
                        output bit err, output int lat);
        drive(p, 1, 0, wr, a, d);
        @(posedge clk); #1;
        drive(p, 1, 1, wr, a, d);
        lat = -1; rd = '0; err = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if ((p == 0) ? m0_pready : m1_pready) begin
                lat = n;
                rd  = (p == 0) ? m0_prdata  : m1_prdata;
                err = (p == 0) ? m0_pslverr : m1_pslverr;
                break;
            end
        end
        if (lat < 0) chk("xfer_completed", 32'd0, 32'd1);
        @(posedge clk); #1;
        drive(p, 0, 0, 0, '0, '0);
    endtask

    logic [DW-1:0] rd, rd0, rd1;
    bit            err, er0, er1;
    int            lat;
    int            lat0 [3];
    int            lat1 [3];
    int            base_acc, base_pulse, g0, n_rel;
    logic [1:0]    rr_exp [6];

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0, '0, '0);
        drive(1, 0, 0, 0, '0, '0);
        slv_wait = 0; slv_stuck = 0; slv_err = 0; slv_rdata = '0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Zero-wait write from M0.
        base_acc = acc_cycles;
        xfer(0, 1, 32'h4000_0010, 32'hDEAD_BEEF, rd, err, lat);
        chk("m0_write_latency", 32'(lat), 32'd3);
        chk("m0_write_err",     32'(err), 32'd0);
        chk("m0_write_addr",    acc_addr,  32'h4000_0010);
        chk("m0_write_data",    acc_wdata, 32'hDEAD_BEEF);
        chk("m0_write_access_cycles", 32'(acc_cycles - base_acc), 32'd1);

        // M1 read with 3 downstream wait states (one short of the watchdog).
        slv_wait = 3; slv_rdata = 32'h1234_5678;
        base_acc = acc_cycles; base_pulse = pulse_cnt;
        xfer(1, 0, 32'h4000_0020, 32'h0, rd, err, lat);
        chk("m1_read_latency", 32'(lat), 32'd6);
        chk("m1_read_data",    rd, 32'h1234_5678);
        chk("m1_read_access_cycles", 32'(acc_cycles - base_acc), 32'd4);
        chk("m1_read_no_timeout", 32'(pulse_cnt - base_pulse), 32'd0);

        // Simultaneous requests right after reset: strict alternation starting at M0.
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        slv_wait = 0; slv_rdata = 32'h0BAD_F00D;
        g0 = grant_log.size();
        fork
            begin
                for (int i = 0; i < 3; i++)
                    xfer(0, 1, 32'h4000_0100 + 32'(i * 4), 32'hA0A0_0000 + 32'(i), rd0, er0, lat0[i]);
            end
            begin
                for (int i = 0; i < 3; i++)
                    xfer(1, 0, 32'h4000_0200 + 32'(i * 4), 32'h0, rd1, er1, lat1[i]);
            end
        join
        rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        chk("rr_grant_count", 32'(grant_log.size() - g0), 32'd6);
        for (int i = 0; i < 6; i++)
            chk("rr_grant_order", (g0 + i < grant_log.size()) ? 32'(grant_log[g0 + i]) : 32'hFFFF_FFFF,
                32'(rr_exp[i]));
        chk("rr_m0_first_latency", 32'(lat0[0]), 32'd3);
        chk("rr_m1_first_latency", 32'(lat1[0]), 32'd7);
        chk("rr_m1_read_data", rd1, 32'h0BAD_F00D);

        // Completer error, then a clean transfer.
        slv_err = 1;
        xfer(1, 1, 32'h4000_0300, 32'h5555_AAAA, rd, err, lat);
        chk("slverr_set", 32'(err), 32'd1);
        slv_err = 0;
        xfer(1, 1, 32'h4000_0304, 32'h5555_AAAB, rd, err, lat);
        chk("slverr_clear", 32'(err), 32'd0);

        // Watchdog: completer never ready.
        slv_stuck = 1; slv_rdata = 32'hFFFF_0000;
        base_acc = acc_cycles; base_pulse = pulse_cnt;
        xfer(0, 0, 32'h4000_0400, 32'h0, rd, err, lat);
        chk("wdog_latency",       32'(lat), 32'd6);
        chk("wdog_access_cycles", 32'(acc_cycles - base_acc), 32'd4);
        chk("wdog_pulse_count",   32'(pulse_cnt - base_pulse), 32'd1);
        chk("wdog_err",           32'(err), 32'd1);
        chk("wdog_rdata",         rd, 32'h0);
        slv_stuck = 0;
        xfer(0, 0, 32'h4000_0404, 32'h0, rd, err, lat);
        chk("after_wdog_latency", 32'(lat), 32'd3);
        chk("after_wdog_err",     32'(err), 32'd0);
        chk("after_wdog_rdata",   rd, 32'hFFFF_0000);

        // Reset during ACCESS, with M1 still requesting through and after reset.
        slv_wait = 5;
        drive(1, 1, 0, 0, 32'h4000_0500, 32'h0);
        @(posedge clk); #1;
        drive(1, 1, 1, 0, 32'h4000_0500, 32'h0);
        @(posedge clk); #1;
        chk("rst_pre_access", 32'(s_penable), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_drops_psel",  32'(s_psel), 32'd0);
        chk("rst_clears_grant", 32'(grant), 32'd0);
        chk("rst_no_pready",   32'(m1_pready), 32'd0);
        @(posedge clk); #1;
        slv_wait = 0;
        rst = 1'b0;
        n_rel = -1;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (m1_pready) begin
                n_rel = n;
                break;
            end
        end
        chk("rst_reserve_latency", 32'(n_rel), 32'd4);
        @(posedge clk); #1;
        drive(1, 0, 0, 0, '0, '0);

        repeat (4) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "bench timeout");
    end

endmodule
